// File: rtl/bit_serializer.sv
// bit_serializer: accepts WIDTH-bit words over valid/ready and emits one bit per clock, MSB- or LSB-first,
// with zero-bubble reload so back-to-back words form a contiguous stream.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = accept ? SHIFT : IDLE;
        else if (ser_last)
            state_nxt = in_valid ? SHIFT : IDLE;
    end

    always_comb begin
        ser_valid = state == SHIFT;
        ser_last  = ser_valid && cnt == LAST;
        in_ready  = state == IDLE || ser_last;
        accept    = in_valid && in_ready;
        busy      = ser_valid;
        ser_bit   = ser_valid ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_BIT;
    end

    // Clearing on the idle-bound last edge keeps cnt within 0..WIDTH-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sr  <= in_data;
            cnt <= '0;
        end else if (ser_last) begin
            sr  <= '0;
            cnt <= '0;
        end else if (ser_valid) begin
            sr  <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: table-driven checks of a 4-bit MSB-first serializer plus hand sequences
// for asynchronous mid-word reset and an 8-bit LSB-first instance.
module tb_bit_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] d4 = '0;
    logic vld4 = 1'b0;
    logic rdy4, bit4, val4, last4, busy4;
    logic [7:0] d8 = '0;
    logic vld8 = 1'b0;
    logic rdy8, bit8, val8, last8, busy8;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(vld4), .in_ready(rdy4),
        .ser_bit(bit4), .ser_valid(val4), .ser_last(last4), .busy(busy4)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(d8), .in_valid(vld8), .in_ready(rdy8),
        .ser_bit(bit8), .ser_valid(val8), .ser_last(last8), .busy(busy8)
    );

    typedef struct packed {
        logic       rst_n;
        logic       vld;
        logic [3:0] d;
        logic       b;
        logic       v;
        logic       l;
        logic       r;
    } vec_t;

    task automatic check(input string name, input int idx, input logic got, input logic exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s #%0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    task automatic check4(input int idx, input logic b, input logic v, input logic l, input logic r);
        check("ser_bit", idx, bit4, b);
        check("ser_valid", idx, val4, v);
        check("ser_last", idx, last4, l);
        check("in_ready", idx, rdy4, r);
        check("busy", idx, busy4, v);
    endtask

    vec_t tv[31];
    logic eb4[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic eb8[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        // {rst_n, in_valid, in_data, exp ser_bit, exp ser_valid, exp ser_last, exp in_ready}
        tv = '{
            {1'b0, 1'b0, 4'b0000, 4'b0001},
            {1'b0, 1'b0, 4'b0000, 4'b0001},
            {1'b1, 1'b0, 4'b0000, 4'b0001},
            {1'b1, 1'b0, 4'b0000, 4'b0001},
            {1'b1, 1'b0, 4'b0000, 4'b0001},
            {1'b1, 1'b1, 4'b1101, 4'b0001},
            {1'b1, 1'b0, 4'b0000, 4'b1100},
            {1'b1, 1'b0, 4'b0000, 4'b1100},
            {1'b1, 1'b0, 4'b0000, 4'b0100},
            {1'b1, 1'b0, 4'b0000, 4'b1111},
            {1'b1, 1'b0, 4'b0000, 4'b0001},
            {1'b1, 1'b1, 4'b1101, 4'b0001},
            {1'b1, 1'b1, 4'b1101, 4'b1100},
            {1'b1, 1'b1, 4'b1101, 4'b1100},
            {1'b1, 1'b1, 4'b1101, 4'b0100},
            {1'b1, 1'b1, 4'b1101, 4'b1111},
            {1'b1, 1'b0, 4'b0000, 4'b1100},
            {1'b1, 1'b0, 4'b0000, 4'b1100},
            {1'b1, 1'b0, 4'b0000, 4'b0100},
            {1'b1, 1'b0, 4'b0000, 4'b1111},
            {1'b1, 1'b0, 4'b0000, 4'b0001},
            {1'b1, 1'b1, 4'b1101, 4'b0001},
            {1'b1, 1'b1, 4'b0000, 4'b1100},
            {1'b1, 1'b1, 4'b1010, 4'b1100},
            {1'b1, 1'b1, 4'b1010, 4'b0100},
            {1'b1, 1'b1, 4'b1010, 4'b1111},
            {1'b1, 1'b0, 4'b0000, 4'b1100},
            {1'b1, 1'b0, 4'b0000, 4'b0100},
            {1'b1, 1'b0, 4'b0000, 4'b1100},
            {1'b1, 1'b0, 4'b0000, 4'b0111},
            {1'b1, 1'b0, 4'b0000, 4'b0001}
        };
        #1;
        check4(-1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            rst_n = tv[i].rst_n;
            vld4  = tv[i].vld;
            d4    = tv[i].d;
            #1;
            check4(i, tv[i].b, tv[i].v, tv[i].l, tv[i].r);
        end

        // Mid-word asynchronous reset after two bits of 1101
        @(negedge clk);
        vld4 = 1'b1;
        d4   = 4'b1101;
        #1 check4(100, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        vld4 = 1'b0;
        #1 check4(101, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1 check4(102, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 check4(103, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check4(104, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1 check4(105, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        vld4 = 1'b1;
        d4   = 4'b0110;
        #1 check4(106, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vld4 = 1'b0;
            d4   = 4'b1111;
            #1 check4(110 + i, eb4[i], 1'b1, i == 3, i == 3);
        end
        @(negedge clk);
        #1 check4(114, 1'b0, 1'b0, 1'b0, 1'b1);

        // LSB-first 8-bit word 0xB4
        @(negedge clk);
        vld8 = 1'b1;
        d8   = 8'hB4;
        #1 check("w8 in_ready", 200, rdy8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vld8 = 1'b0;
            d8   = 8'h00;
            #1;
            check("w8 ser_bit", 201 + i, bit8, eb8[i]);
            check("w8 ser_valid", 201 + i, val8, 1'b1);
            check("w8 ser_last", 201 + i, last8, i == 7);
        end
        @(negedge clk);
        #1;
        check("w8 ser_valid", 210, val8, 1'b0);
        check("w8 ser_bit", 210, bit8, 1'b0);
        check("w8 busy", 210, busy8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
